// File: rtl/i2c_slave_multi.sv
// I2C register-access slave serving NUM_DEV consecutive device addresses.
// It exposes CSR read/write strobes and stretches SCL while read data is fetched.
module i2c_slave_multi #(
  parameter logic [6:0] I2C_ADDRESS = 7'h4a,
  parameter int         NUM_DEV     = 2,
  parameter int         IDX_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sda,
  output logic                 sda_out,
  input  logic                 scl,
  output logic                 scl_out,
  output logic [1:0]           csr_dev,
  output logic [IDX_WIDTH-1:0] csr_a,
  output logic                 csr_re,
  input  logic                 csr_rdy,
  input  logic [7:0]           csr_di,
  output logic                 csr_we,
  output logic [7:0]           csr_do
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEV_ADDR = 3'd1,
    ST_IDX_PTR  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_FETCH    = 3'd4,
    ST_READ     = 3'd5
  } state_t;

  localparam logic [6:0]           DEV_LIMIT = 7'(NUM_DEV);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE   = IDX_WIDTH'(1'b1);

  state_t state_r, state_nxt_s;
  logic [1:0] sda_sync_r, scl_sync_r;
  logic sda_d_r, scl_d_r, sda_s, scl_s;
  logic start_s, stop_s, capture_s, update_s, ack_bit_s;
  logic [3:0] cnt_r;
  logic [7:0] rx_r, tx_r, fetch_data_s;
  logic [6:0] addr_off_s;
  logic addr_hit_s, rdy_s, have_r, upd_r;
  logic sda_out_r, scl_out_r, csr_re_r, csr_we_r;
  logic [1:0] csr_dev_r;
  logic [IDX_WIDTH-1:0] csr_a_r;
  logic [7:0] csr_do_r;
  logic sda_nxt_s, scl_nxt_s, re_nxt_s, we_nxt_s;
  logic idx_load_s, a_inc_s, dev_load_s, tx_load_s, tx_shift_s;
  logic fetch_init_s, have_set_s, upd_set_s;

  assign sda_s     = sda_sync_r[1];
  assign scl_s     = scl_sync_r[1];
  assign start_s   = scl_s & scl_d_r & sda_d_r & ~sda_s;
  assign stop_s    = scl_s & scl_d_r & ~sda_d_r & sda_s;
  assign capture_s = scl_s & ~scl_d_r;
  assign update_s  = ~scl_s & scl_d_r;
  assign ack_bit_s = capture_s && (cnt_r == 4'd8);

  assign addr_off_s   = rx_r[7:1] - I2C_ADDRESS;
  assign addr_hit_s   = addr_off_s < DEV_LIMIT;
  // Read data is only trusted from the cycle after the request strobe.
  assign rdy_s        = csr_rdy & ~csr_re_r;
  assign fetch_data_s = have_r ? tx_r : csr_di;

  assign sda_out = sda_out_r;
  assign scl_out = scl_out_r;
  assign csr_dev = csr_dev_r;
  assign csr_a   = csr_a_r;
  assign csr_re  = csr_re_r;
  assign csr_we  = csr_we_r;
  assign csr_do  = csr_do_r;

  // Bus line synchronisers and previous-value registers for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sda_sync_r <= 2'b11;
      scl_sync_r <= 2'b11;
      sda_d_r    <= 1'b1;
      scl_d_r    <= 1'b1;
    end else begin
      sda_sync_r <= {sda_sync_r[0], sda};
      scl_sync_r <= {scl_sync_r[0], scl};
      sda_d_r    <= sda_sync_r[1];
      scl_d_r    <= scl_sync_r[1];
    end
  end

  // Protocol state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle actions; start/stop override everything
  always_comb begin
    state_nxt_s  = state_r;
    sda_nxt_s    = sda_out_r;
    scl_nxt_s    = scl_out_r;
    re_nxt_s     = 1'b0;
    we_nxt_s     = 1'b0;
    idx_load_s   = 1'b0;
    a_inc_s      = 1'b0;
    dev_load_s   = 1'b0;
    tx_load_s    = 1'b0;
    tx_shift_s   = 1'b0;
    fetch_init_s = 1'b0;
    have_set_s   = 1'b0;
    upd_set_s    = 1'b0;
    if (start_s) begin
      state_nxt_s = ST_DEV_ADDR;
      sda_nxt_s   = 1'b1;
      scl_nxt_s   = 1'b1;
    end else if (stop_s) begin
      state_nxt_s = ST_IDLE;
      sda_nxt_s   = 1'b1;
      scl_nxt_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sda_nxt_s = 1'b1;
          scl_nxt_s = 1'b1;
        end
        ST_DEV_ADDR: begin
          if (update_s) begin
            sda_nxt_s = ~((cnt_r == 4'd8) & addr_hit_s);
          end else begin
            sda_nxt_s = sda_out_r;
          end
          if (ack_bit_s) begin
            dev_load_s = addr_hit_s;
            if (!addr_hit_s) begin
              state_nxt_s = ST_IDLE;
            end else if (rx_r[0]) begin
              state_nxt_s  = ST_FETCH;
              re_nxt_s     = 1'b1;
              fetch_init_s = 1'b1;
            end else begin
              state_nxt_s = ST_IDX_PTR;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_IDX_PTR, ST_WRITE: begin
          if (update_s) begin
            sda_nxt_s = (cnt_r != 4'd8);
          end else begin
            sda_nxt_s = sda_out_r;
          end
          if (ack_bit_s) begin
            idx_load_s  = (state_r == ST_IDX_PTR);
            we_nxt_s    = (state_r == ST_WRITE);
            state_nxt_s = ST_WRITE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_FETCH: begin
          // upd_r: the update edge has passed without data, so SCL is being held
          if (upd_r) begin
            if (rdy_s) begin
              sda_nxt_s   = csr_di[7];
              scl_nxt_s   = 1'b1;
              tx_load_s   = 1'b1;
              state_nxt_s = ST_READ;
            end else begin
              scl_nxt_s = 1'b0;
            end
          end else if (update_s) begin
            if (have_r || rdy_s) begin
              sda_nxt_s   = fetch_data_s[7];
              tx_load_s   = 1'b1;
              state_nxt_s = ST_READ;
            end else begin
              sda_nxt_s = 1'b1;
              scl_nxt_s = 1'b0;
              upd_set_s = 1'b1;
            end
          end else if (rdy_s && !have_r) begin
            tx_load_s  = 1'b1;
            have_set_s = 1'b1;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_READ: begin
          if (update_s) begin
            if (cnt_r == 4'd8) begin
              sda_nxt_s = 1'b1;
            end else begin
              sda_nxt_s  = tx_r[6];
              tx_shift_s = 1'b1;
            end
          end else begin
            sda_nxt_s = sda_out_r;
          end
          if (ack_bit_s) begin
            if (!sda_s) begin
              a_inc_s      = 1'b1;
              re_nxt_s     = 1'b1;
              fetch_init_s = 1'b1;
              state_nxt_s  = ST_FETCH;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          sda_nxt_s   = 1'b1;
          scl_nxt_s   = 1'b1;
        end
      endcase
    end
  end

  // Bit counter, shifters, fetch bookkeeping, line drives and CSR outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= 4'd0;
      rx_r      <= 8'hff;
      tx_r      <= 8'hff;
      have_r    <= 1'b0;
      upd_r     <= 1'b0;
      sda_out_r <= 1'b1;
      scl_out_r <= 1'b1;
      csr_re_r  <= 1'b0;
      csr_we_r  <= 1'b0;
      csr_dev_r <= 2'd0;
      csr_a_r   <= {IDX_WIDTH{1'b0}};
      csr_do_r  <= 8'd0;
    end else begin
      if (start_s) begin
        cnt_r <= 4'd0;
      end else if (capture_s) begin
        cnt_r <= (cnt_r == 4'd8) ? 4'd0 : cnt_r + 4'd1;
      end
      if (capture_s && (cnt_r != 4'd8)) begin
        rx_r <= {rx_r[6:0], sda_s};
      end
      if (tx_load_s) begin
        tx_r <= fetch_data_s;
      end else if (tx_shift_s) begin
        tx_r <= {tx_r[6:0], 1'b0};
      end
      if (fetch_init_s) begin
        have_r <= 1'b0;
        upd_r  <= 1'b0;
      end else begin
        if (have_set_s) have_r <= 1'b1;
        if (upd_set_s)  upd_r  <= 1'b1;
      end
      sda_out_r <= sda_nxt_s;
      scl_out_r <= scl_nxt_s;
      csr_re_r  <= re_nxt_s;
      csr_we_r  <= we_nxt_s;
      if (we_nxt_s)   csr_do_r  <= rx_r;
      if (dev_load_s) csr_dev_r <= addr_off_s[1:0];
      // Write strobes advance the index on the cycle after the strobe
      if (idx_load_s) begin
        csr_a_r <= rx_r[IDX_WIDTH-1:0];
      end else if (a_inc_s || csr_we_r) begin
        csr_a_r <= csr_a_r + IDX_ONE;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_multi.sv
// Directed bench for i2c_slave_multi: bus master model, CSR responder and a
// strobe scoreboard, all serviced from one sequential process.
`timescale 1ns/1ps
module tb_i2c_slave_multi;

  localparam int H = 8;

  typedef struct packed {
    logic       we;
    logic [1:0] dev;
    logic [4:0] a;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sda_m, scl_m, bypass;
  logic sda_bus, scl_bus;
  logic sda_out, scl_out, csr_re, csr_we, csr_rdy;
  logic [1:0] csr_dev;
  logic [4:0] csr_a;
  logic [7:0] csr_di, csr_do;

  ev_t sb_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int rsp_cnt = 0;
  int rsp_delay = 5;

  assign sda_bus = sda_m & sda_out;
  assign scl_bus = scl_m & (scl_out | bypass);

  i2c_slave_multi dut (
    .clk(clk), .rst(rst), .sda(sda_bus), .sda_out(sda_out), .scl(scl_bus), .scl_out(scl_out),
    .csr_dev(csr_dev), .csr_a(csr_a), .csr_re(csr_re), .csr_rdy(csr_rdy), .csr_di(csr_di),
    .csr_we(csr_we), .csr_do(csr_do)
  );

  function automatic logic [7:0] rd_pat(input logic [1:0] dev, input logic [4:0] a);
    return {a, 1'b0, dev} ^ 8'h5a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_we(input logic [1:0] dev, input logic [4:0] a, input logic [7:0] d);
    sb_q.push_back('{we: 1'b1, dev: dev, a: a, d: d});
  endtask

  task automatic push_re(input logic [1:0] dev, input logic [4:0] a);
    sb_q.push_back('{we: 1'b0, dev: dev, a: a, d: 8'h00});
  endtask

  // One clock step: CSR responder plus scoreboard check of any strobe
  task automatic tick();
    ev_t e;
    @(negedge clk);
    csr_rdy = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) csr_rdy = 1'b1;
    end
    if (csr_re === 1'b1) begin
      rsp_cnt = rsp_delay;
      csr_di  = rd_pat(csr_dev, csr_a);
    end
    if (csr_we === 1'b1 || csr_re === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_strobe", {30'd0, csr_we, csr_re}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_kind", {31'd0, csr_we}, {31'd0, e.we});
        chk("strobe_dev", {30'd0, csr_dev}, {30'd0, e.dev});
        chk("strobe_a", {27'd0, csr_a}, {27'd0, e.a});
        if (e.we) chk("strobe_data", {24'd0, csr_do}, {24'd0, e.d});
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic scl_rise();
    int k;
    k = 0;
    scl_m = 1'b1;
    while (scl_bus !== 1'b1 && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) chk("scl_release_timeout", {31'd0, scl_bus}, 32'd1);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_cyc(H);
    scl_rise();   wait_cyc(H);
    sda_m = 1'b0; wait_cyc(H);
    scl_m = 1'b0; wait_cyc(H);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_cyc(H);
    scl_rise();   wait_cyc(H);
    sda_m = 1'b1; wait_cyc(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_cyc(H);
      scl_rise();   wait_cyc(H);
      scl_m = 1'b0; wait_cyc(2);
    end
    sda_m = 1'b1; wait_cyc(H);
    scl_rise();   wait_cyc(H / 2);
    ack = ~sda_bus;
    wait_cyc(H / 2);
    scl_m = 1'b0; wait_cyc(2);
  endtask

  task automatic read_byte(input logic ack_m, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_cyc(H);
      scl_rise();   wait_cyc(H / 2);
      b[i] = sda_bus;
      wait_cyc(H / 2);
      scl_m = 1'b0; wait_cyc(2);
    end
    sda_m = ~ack_m; wait_cyc(H);
    scl_rise();     wait_cyc(H);
    scl_m = 1'b0;   wait_cyc(2);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b, exp_b;
    int         k;
    rst = 1'b1; sda_m = 1'b1; scl_m = 1'b1; bypass = 1'b0;
    csr_rdy = 1'b0; csr_di = 8'h00;
    tick();
    rst = 1'b0;
    wait_cyc(4);
    chk("rst_sda_out", {31'd0, sda_out}, 32'd1);
    chk("rst_scl_out", {31'd0, scl_out}, 32'd1);
    chk("rst_csr_re", {31'd0, csr_re}, 32'd0);
    chk("rst_csr_we", {31'd0, csr_we}, 32'd0);
    chk("rst_csr_a", {27'd0, csr_a}, 32'd0);
    chk("rst_csr_dev", {30'd0, csr_dev}, 32'd0);
    chk("rst_csr_do", {24'd0, csr_do}, 32'd0);
    rst = 1'b1;
    wait_cyc(5);

    // Plain write of two data bytes to device 0 starting at index 3
    push_we(2'd0, 5'd3, 8'ha5);
    push_we(2'd0, 5'd4, 8'h5a);
    i2c_start();
    write_byte(8'h94, ack); chk("wr_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h03, ack); chk("wr_idx_ack", {31'd0, ack}, 32'd1);
    write_byte(8'ha5, ack); chk("wr_d0_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h5a, ack); chk("wr_d1_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    wait_cyc(10);
    chk("wr_sb_empty", sb_q.size(), 32'd0);
    chk("wr_csr_a", {27'd0, csr_a}, 32'd5);

    // Device 1: set index 4, repeated start, read two bytes (ACK then NACK)
    rsp_delay = 5;
    push_re(2'd1, 5'd4);
    push_re(2'd1, 5'd5);
    i2c_start();
    write_byte(8'h96, ack); chk("rd_waddr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h04, ack); chk("rd_idx_ack", {31'd0, ack}, 32'd1);
    i2c_start();
    write_byte(8'h97, ack); chk("rd_raddr_ack", {31'd0, ack}, 32'd1);
    chk("rd_csr_dev", {30'd0, csr_dev}, 32'd1);
    read_byte(1'b1, b); chk("rd_byte0", {24'd0, b}, {24'd0, rd_pat(2'd1, 5'd4)});
    read_byte(1'b0, b); chk("rd_byte1", {24'd0, b}, {24'd0, rd_pat(2'd1, 5'd5)});
    i2c_stop();
    wait_cyc(20);
    chk("rd_sb_empty", sb_q.size(), 32'd0);

    // Slow read data: SCL held low until csr_rdy, bit 7 presented on release
    rsp_delay = 200;
    push_re(2'd1, 5'd5);
    exp_b = rd_pat(2'd1, 5'd5);
    i2c_start();
    write_byte(8'h97, ack); chk("st_addr_ack", {31'd0, ack}, 32'd1);
    wait_cyc(10);
    chk("st_scl_held", {31'd0, scl_out}, 32'd0);
    chk("st_sda_released", {31'd0, sda_out}, 32'd1);
    k = 0;
    while (scl_out !== 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    chk("st_release_bit7", {31'd0, sda_out}, {31'd0, exp_b[7]});
    chk("st_stretch_len", {31'd0, (k >= 150 && k < 1000)}, 32'd1);
    read_byte(1'b0, b); chk("st_byte", {24'd0, b}, {24'd0, exp_b});
    i2c_stop();
    wait_cyc(10);

    // Address outside the served range: NACK and stay idle
    i2c_start();
    write_byte(8'h98, ack); chk("na_addr_nack", {31'd0, ack}, 32'd0);
    write_byte(8'h00, ack); chk("na_idle_nack", {31'd0, ack}, 32'd0);
    i2c_stop();
    wait_cyc(10);
    chk("na_sb_empty", sb_q.size(), 32'd0);
    chk("na_csr_a", {27'd0, csr_a}, 32'd5);

    // Index wrap from 0x1f to 0
    push_we(2'd0, 5'h1f, 8'h11);
    push_we(2'd0, 5'h00, 8'h22);
    i2c_start();
    write_byte(8'h94, ack); chk("wp_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h1f, ack); chk("wp_idx_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h11, ack); chk("wp_d0_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h22, ack); chk("wp_d1_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    wait_cyc(10);
    chk("wp_sb_empty", sb_q.size(), 32'd0);
    chk("wp_csr_a", {27'd0, csr_a}, 32'd1);

    // Repeated start forced onto the bus while the slave is stretching
    rsp_delay = 300;
    push_re(2'd0, 5'd1);
    i2c_start();
    write_byte(8'h95, ack); chk("rs_addr_ack", {31'd0, ack}, 32'd1);
    wait_cyc(10);
    chk("rs_stretching", {31'd0, scl_out}, 32'd0);
    bypass = 1'b1;
    scl_m  = 1'b1; wait_cyc(H);
    sda_m  = 1'b0; wait_cyc(4);
    chk("rs_scl_released", {31'd0, scl_out}, 32'd1);
    chk("rs_sda_released", {31'd0, sda_out}, 32'd1);
    wait_cyc(H - 4);
    scl_m  = 1'b0; wait_cyc(2);
    bypass = 1'b0; wait_cyc(H);
    push_we(2'd0, 5'd7, 8'h33);
    write_byte(8'h94, ack); chk("rs_waddr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h07, ack); chk("rs_idx_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h33, ack); chk("rs_data_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    wait_cyc(20);
    chk("rs_sb_empty", sb_q.size(), 32'd0);
    chk("rs_csr_a", {27'd0, csr_a}, 32'd8);

    // Reset while the slave drives a 0 data bit, then a fresh transaction
    rsp_delay = 2;
    push_re(2'd0, 5'd8);
    exp_b = rd_pat(2'd0, 5'd8);
    i2c_start();
    write_byte(8'h95, ack); chk("rr_addr_ack", {31'd0, ack}, 32'd1);
    wait_cyc(6);
    chk("rr_no_stretch", {31'd0, scl_out}, 32'd1);
    chk("rr_bit7_driven", {31'd0, sda_out}, {31'd0, exp_b[7]});
    #3 rst = 1'b0;
    #1;
    chk("rr_async_sda", {31'd0, sda_out}, 32'd1);
    chk("rr_async_scl", {31'd0, scl_out}, 32'd1);
    wait_cyc(3);
    chk("rr_csr_a", {27'd0, csr_a}, 32'd0);
    chk("rr_csr_dev", {30'd0, csr_dev}, 32'd0);
    rst = 1'b1;
    wait_cyc(5);
    push_we(2'd1, 5'd2, 8'h44);
    i2c_start();
    write_byte(8'h96, ack); chk("rr_waddr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h02, ack); chk("rr_idx_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h44, ack); chk("rr_data_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    wait_cyc(20);
    chk("rr_sb_empty", sb_q.size(), 32'd0);
    chk("rr_csr_dev_after", {30'd0, csr_dev}, 32'd1);
    chk("rr_csr_a_after", {27'd0, csr_a}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
